sha256_stream_hasher: RTL and testbench
=======================================

# sha256_stream_hasher

Parametrised, multi-block SHA-256 engine that hashes a word-aligned message of runtime-selectable length, read from the shared single-port memory. It performs FIPS 180-4 padding in hardware for any length, processes as many 512-bit blocks as needed at one round per cycle, and writes the 8-word digest back to memory. The digest is also presented on a port. It replaces the fixed-length hasher in the memory-mapped hashing subsystem.

## Interface
- `ADDR_W`, 16: memory word-address width.
- `LEN_W`, 16: width of `num_words`. Maximum message is 2^LEN_W − 1 words.
- `clk`  in  1: sole clock.
- `reset`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a hash. Sampled only while idle.
- `num_words`  in  LEN_W: message length L in 32-bit words. Captured at start.
- `message_addr`  in  ADDR_W: address of word 0. Captured at start.
- `output_addr`  in  ADDR_W: address of digest word 0. Captured at start.
- `busy`  out  1: high from the accepting edge until the DONE state is left.
- `done`  out  1: one-cycle pulse when the digest is complete.
- `digest`  out  256: H0..H7, with H0 in bits [255:224]. Held until the next start.
- `mem_clk`  out  1: equal to `clk`.
- `mem_we`  out  1: write strobe.
- `mem_addr`  out  ADDR_W: word address.
- `mem_write_data`  out  32: write data.
- `mem_read_data`  in  32: read data. Valid in the cycle after its address is driven.

## Operation
- Reset values: `busy`, `done`, `mem_we` = 0; `mem_addr`, `mem_write_data`, `digest` = 0; state = IDLE.
- Block count: B = ceil((L+3)/16). Examples: L=0→1, L=13→1, L=14→2, L=20→2.
- Padded word j, for 0 ≤ j < 16B:
  - j < L: the memory word.
  - j = L: 0x80000000.
  - j = 16B−2: 0.
  - j = 16B−1: L·32, truncated to 32 bits.
  - all other j: 0.
- Read addresses are message_addr + j mod 2^ADDR_W. Reads are issued only for j < L; padding words never touch memory.
- States:
  - IDLE: on `start`, capture the inputs, load H = FIPS initial values, set blk = 0, go to LOAD.
  - LOAD (17 cycles): cycle c ≤ 15 drives the address of word 16·blk + c. Cycle c ≥ 1 captures padded word c−1 into W[c−1]. Then go to PRE.
  - PRE (1 cycle): a..h ← H; P ← W[0] + K[0] + H7.
  - ROUND (64 cycles): one compression round per cycle using the precomputed P. The 16-word window shifts each cycle, with new W = σ1(W[14]) + W[9] + σ0(W[1]) + W[0]. All arithmetic is mod 2^32. Then go to ACC.
  - ACC (1 cycle): H[i] ← H[i] + working variable i. blk++. Go to LOAD if blk < B, else go to WRITE.
  - WRITE (8 cycles): cycle i drives `mem_we`=1, addr = output_addr + i mod 2^ADDR_W, data = H[i]. `digest` updates on entry.
  - DONE (1 cycle): `done`=1, `mem_we`=0, then go to IDLE.
- `start` outside IDLE is ignored; inputs latched earlier are unaffected.
- `mem_we` is 0 in every state except WRITE.

## Timing
- 83 cycles per block (17 + 1 + 64 + 1).
- `done` is high for exactly one cycle, beginning 83·B + 8 edges after the edge that accepted `start`.
- Back-to-back: `start` high in the DONE cycle is ignored. `start` in the first IDLE cycle after DONE is accepted.
- `reset` asserted at any point forces IDLE and drops `mem_we` the same instant. No further reads or writes occur. A partial digest is never written.
- Zero-length message (L=0): no reads are issued, and LOAD still takes 17 cycles.

## Structure
- `sha256_pkg`:
  - K[0:63] table and H initial constants.
  - State enum.
  - Functions `rightrotate`, `sigma0`, `sigma1`, `sha256_round`, `pad_word`.
- Sub-module `sha256_compress`:
  - Owns the W window, P pipeline register and working variables.
  - Ports: init/H in, round-enable, load-word interface, done-of-64 flag, a..h out.
- Top level: FSM, address generation, padding, H accumulation and the write-back path.

## Test plan
- L=0 → reads none; digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855; done at edge 91.
- L=20, random words → digest matches the software model; 2 blocks; done at edge 174; 8 writes to output_addr..+7 in order.
- L=13 and L=14, same prefix → B=1 (done at 91) vs B=2 (done at 174); length word = 416 / 448; both digests match the model.
- message_addr=0xFFFA, L=10 → reads 0xFFFA..0xFFFF then 0x0000..0x0003; digest matches the model.
- `reset` pulsed at round 30 of block 1 (L=20) → `busy`=0 and `mem_we`=0 immediately; no writes; a fresh start then yields the correct digest.
- `start` re-asserted while busy with different addresses → ignored; output is written only to the originally latched output_addr.

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 round constants, initial hash value, FSM encoding and the round/schedule/padding helpers
// shared by the stream hasher and its compression core.
package sha256_pkg;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] H_INIT = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_PRE, ST_ROUND, ST_ACC, ST_WRITE, ST_DONE
  } state_e;

  function automatic logic [31:0] rightrotate(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rightrotate(x, 7) ^ rightrotate(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rightrotate(x, 17) ^ rightrotate(x, 19) ^ (x >> 10);
  endfunction

  // s holds a..g; h is already folded into the precomputed p = W + K + h.
  function automatic logic [255:0] sha256_round(input logic [223:0] s, input logic [31:0] p);
    logic [31:0] a, b, c, d, e, f, g, t1, t2;
    {a, b, c, d, e, f, g} = s;
    t1 = p + (rightrotate(e, 6) ^ rightrotate(e, 11) ^ rightrotate(e, 25)) + ((e & f) ^ (~e & g));
    t2 = (rightrotate(a, 2) ^ rightrotate(a, 13) ^ rightrotate(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic logic [31:0] pad_word(input logic [31:0] j, input logic [31:0] len,
                                           input logic [31:0] last_j, input logic [31:0] mem_word);
    if (j < len) return mem_word;
    if (j == len) return 32'h8000_0000;
    if (j == last_j) return len << 5;
    return 32'h0;
  endfunction

endpackage

// File: rtl/sha256_stream_hasher_compress.sv
// SHA-256 compression core: 16-word message window, precomputed P register and working variables,
// advancing one round per enabled cycle.
module sha256_compress
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         init_i,
  input  logic [255:0] h_i,
  input  logic         round_en_i,
  input  logic         load_en_i,
  input  logic [3:0]   load_idx_i,
  input  logic [31:0]  load_word_i,
  output logic         rounds_done_o,
  output logic [255:0] work_o
);

  logic [31:0]  w_q [16];
  logic [31:0]  w_d [16];
  logic [31:0]  p_q, p_d;
  logic [255:0] work_q, work_d;
  logic [5:0]   rnd_q, rnd_d;

  always_comb begin
    w_d    = w_q;
    p_d    = p_q;
    work_d = work_q;
    rnd_d  = rnd_q;
    if (load_en_i) w_d[load_idx_i] = load_word_i;
    if (init_i) begin
      work_d = h_i;
      p_d    = w_q[0] + K[0] + h_i[31:0];
      rnd_d  = '0;
    end else if (round_en_i) begin
      work_d = sha256_round(work_q[255:32], p_q);
      // Next round's h is this round's g, so P for round t+1 is ready one cycle early.
      p_d    = w_q[1] + K[rnd_q + 6'd1] + work_q[63:32];
      for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
      w_d[15] = sigma1(w_q[14]) + w_q[9] + sigma0(w_q[1]) + w_q[0];
      rnd_d  = rnd_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      p_q    <= '0;
      work_q <= '0;
      rnd_q  <= '0;
    end else begin
      w_q    <= w_d;
      p_q    <= p_d;
      work_q <= work_d;
      rnd_q  <= rnd_d;
    end
  end

  assign rounds_done_o = round_en_i && (rnd_q == 6'd63);
  assign work_o        = work_q;

endmodule

// File: rtl/sha256_stream_hasher.sv
// Multi-block SHA-256 over a word-aligned message in shared memory: hardware padding, one round per
// cycle, digest written back to memory and presented on a port.
module sha256_stream_hasher
  import sha256_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  num_words,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              busy,
  output logic              done,
  output logic [255:0]      digest,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  state_e             state_q, state_d;
  logic [4:0]         cyc_q, cyc_d;
  logic [LEN_W-1:0]   blk_q, blk_d, nblk_q, nblk_d, len_q, len_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d, oaddr_q, oaddr_d;
  logic [7:0][31:0]   h_q, h_d;
  logic [255:0]       digest_q, digest_d;
  logic [7:0][31:0]   work;
  logic [LEN_W+3:0]   rd_j, cap_j;
  logic [3:0]         cap_idx;
  logic [31:0]        load_word;
  logic               init, round_en, load_en, rounds_done;

  assign mem_clk = clk;
  assign digest  = digest_q;
  assign rd_j    = {blk_q, cyc_q[3:0]};
  assign cap_idx = cyc_q[3:0] - 4'd1;
  assign cap_j   = {blk_q, cap_idx};
  assign load_word = pad_word(32'(cap_j), 32'(len_q), 32'({nblk_q, 4'h0}) - 32'd1, mem_read_data);

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    blk_d    = blk_q;
    nblk_d   = nblk_q;
    len_d    = len_q;
    maddr_d  = maddr_q;
    oaddr_d  = oaddr_q;
    h_d      = h_q;
    digest_d = digest_q;
    init     = 1'b0;
    round_en = 1'b0;
    load_en  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_write_data = '0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          len_d   = num_words;
          nblk_d  = LEN_W'(({1'b0, num_words} + (LEN_W+1)'(18)) >> 4);
          maddr_d = message_addr;
          oaddr_d = output_addr;
          h_d     = H_INIT;
          blk_d   = '0;
          cyc_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Padding words are synthesised locally; the address bus stays at 0 for them.
        if (!cyc_q[4] && (rd_j < (LEN_W+4)'(len_q))) mem_addr = maddr_q + ADDR_W'(rd_j);
        load_en = (cyc_q != 5'd0);
        if (cyc_q == 5'd16) state_d = ST_PRE;
        else cyc_d = cyc_q + 5'd1;
      end
      ST_PRE: begin
        init    = 1'b1;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        round_en = 1'b1;
        if (rounds_done) state_d = ST_ACC;
      end
      ST_ACC: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + work[i];
        blk_d = blk_q + 1'b1;
        cyc_d = '0;
        if (blk_d < nblk_q) begin
          state_d = ST_LOAD;
        end else begin
          digest_d = h_d;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we         = 1'b1;
        mem_addr       = oaddr_q + ADDR_W'(cyc_q);
        mem_write_data = h_q[3'd7 - cyc_q[2:0]];
        if (cyc_q == 5'd7) state_d = ST_DONE;
        else cyc_d = cyc_q + 5'd1;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      blk_q    <= '0;
      nblk_q   <= '0;
      len_q    <= '0;
      maddr_q  <= '0;
      oaddr_q  <= '0;
      h_q      <= '0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      blk_q    <= blk_d;
      nblk_q   <= nblk_d;
      len_q    <= len_d;
      maddr_q  <= maddr_d;
      oaddr_q  <= oaddr_d;
      h_q      <= h_d;
      digest_q <= digest_d;
    end
  end

  sha256_compress u_compress (
    .clk           (clk),
    .reset         (reset),
    .init_i        (init),
    .h_i           (h_q),
    .round_en_i    (round_en),
    .load_en_i     (load_en),
    .load_idx_i    (cap_idx),
    .load_word_i   (load_word),
    .rounds_done_o (rounds_done),
    .work_o        (work)
  );

endmodule

// File: tb/tb_sha256_stream_hasher.sv
// Directed bench for sha256_stream_hasher: FIPS vectors, a reference SHA-256 model, latency,
// address-trace, write-back, reset and start-while-busy scenarios.
module tb_sha256_stream_hasher;

  localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] D_ABC56 = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  logic reset, start, busy, done, mem_clk, mem_we;
  logic [15:0] num_words, message_addr, output_addr, mem_addr;
  logic [31:0] mem_write_data, mem_read_data;
  logic [255:0] digest;

  logic [31:0] rom [65536];
  logic [31:0] msg_buf [64];
  logic [15:0] hist [4096];
  logic [15:0] wr_addr [256];
  logic [31:0] wr_data [256];
  int cyc_cnt = 0, wr_cnt = 0;
  int checks = 0, errors = 0;
  int acc, edges, base, nz;
  logic [255:0] exp20, expv, obs_v, exp_v;

  always #5 clk = ~clk;

  sha256_stream_hasher #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .message_addr(message_addr), .output_addr(output_addr),
    .busy(busy), .done(done), .digest(digest), .mem_clk(mem_clk),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    mem_read_data <= rom[mem_addr];
    if (mem_we) begin
      wr_addr[wr_cnt % 256] <= mem_addr;
      wr_data[wr_cnt % 256] <= mem_write_data;
      wr_cnt <= wr_cnt + 1;
    end
  end

  always @(negedge clk) hist[cyc_cnt % 4096] <= mem_addr;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sw_sha(input int len);
    logic [31:0] h [8];
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    int nb;
    nb = (len + 2) / 16 + 1;
    h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < nb; blk++) begin
      for (int t = 0; t < 16; t++) begin
        if (blk * 16 + t < len) w[t] = msg_buf[blk * 16 + t];
        else if (blk * 16 + t == len) w[t] = 32'h80000000;
        else if (blk * 16 + t == nb * 16 - 1) w[t] = 32'(len * 32);
        else w[t] = 32'h0;
      end
      for (int t = 16; t < 64; t++)
        w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
        t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
    end
    return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_msg(input logic [15:0] ma, input int len);
    for (int i = 0; i < len; i++) rom[16'(ma + i)] = msg_buf[i];
  endtask

  task automatic do_start(input logic [15:0] len, input logic [15:0] ma, input logic [15:0] oa);
    @(negedge clk);
    num_words = len; message_addr = ma; output_addr = oa; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    acc = cyc_cnt;
  endtask

  task automatic wait_done(output int e);
    e = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        e = cyc_cnt - acc;
        break;
      end
    end
  endtask

  task automatic check_writes(input string tag, input int b, input logic [15:0] oa, input logic [255:0] expd);
    logic [255:0] oa_v, ea_v, od_v;
    oa_v = '0; ea_v = '0; od_v = '0;
    check({tag, "_wr_count"}, 256'(wr_cnt - b), 256'(8));
    for (int i = 0; i < 8; i++) begin
      oa_v = {oa_v[239:0], wr_addr[(b + i) % 256]};
      ea_v = {ea_v[239:0], 16'(oa + i)};
      od_v = {od_v[223:0], wr_data[(b + i) % 256]};
    end
    check({tag, "_wr_addr"}, oa_v, ea_v);
    check({tag, "_wr_data"}, od_v, expd);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_words = '0; message_addr = '0; output_addr = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, mem_we, mem_addr, mem_write_data, digest},
          {1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 256'h0});
    reset = 1'b0;

    // Empty message: one block, no memory reads.
    base = wr_cnt;
    do_start(16'd0, 16'h1234, 16'h0100);
    wait_done(edges);
    check("l0_done_edge", 256'(edges), 256'(91));
    check("l0_digest", digest, D_EMPTY);
    nz = 0;
    for (int k = 0; k < 83; k++) if (hist[(acc + k) % 4096] != 16'h0) nz++;
    check("l0_no_reads", 256'(nz), 256'(0));
    @(negedge clk);
    check("l0_done_pulse", {254'h0, done, busy}, 256'h0);
    check_writes("l0", base, 16'h0100, D_EMPTY);

    // FIPS two-block vector: 56 bytes "abcdbcdecdef...nopq" = 14 words.
    for (int i = 0; i < 14; i++) msg_buf[i] = {8'(8'h61 + i), 8'(8'h62 + i), 8'(8'h63 + i), 8'(8'h64 + i)};
    load_msg(16'h0200, 14);
    do_start(16'd14, 16'h0200, 16'h0300);
    wait_done(edges);
    check("l14_done_edge", 256'(edges), 256'(174));
    check("l14_digest", digest, D_ABC56);

    // Same prefix, 13 words: padding still fits one block.
    do_start(16'd13, 16'h0200, 16'h0300);
    wait_done(edges);
    check("l13_done_edge", 256'(edges), 256'(91));
    check("l13_digest", digest, sw_sha(13));

    // 20 random words.
    for (int i = 0; i < 20; i++) msg_buf[i] = $urandom;
    load_msg(16'h0400, 20);
    exp20 = sw_sha(20);
    base = wr_cnt;
    do_start(16'd20, 16'h0400, 16'h0500);
    wait_done(edges);
    check("l20_done_edge", 256'(edges), 256'(174));
    check("l20_digest", digest, exp20);
    check_writes("l20", base, 16'h0500, exp20);

    // Read addresses wrap past the top of the address space.
    for (int i = 0; i < 10; i++) msg_buf[i] = 32'hA5C30000 ^ (32'(i) * 32'h01234567);
    load_msg(16'hFFFA, 10);
    expv = sw_sha(10);
    do_start(16'd10, 16'hFFFA, 16'h0600);
    wait_done(edges);
    obs_v = '0; exp_v = '0;
    for (int k = 0; k < 16; k++) begin
      obs_v = {obs_v[239:0], hist[(acc + k) % 4096]};
      exp_v = {exp_v[239:0], (k < 10) ? 16'(16'hFFFA + k) : 16'h0};
    end
    check("wrap_addr_trace", obs_v, exp_v);
    check("wrap_digest", digest, expv);

    // Reset during round 30 of the second block.
    base = wr_cnt;
    do_start(16'd20, 16'h0400, 16'h0700);
    repeat (131) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("rst_immediate", {253'h0, busy, mem_we, done}, 256'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_no_writes", 256'(wr_cnt - base), 256'(0));
    do_start(16'd20, 16'h0400, 16'h0700);
    wait_done(edges);
    check("rst_restart_digest", digest, exp20);

    // start while busy with different parameters is ignored.
    base = wr_cnt;
    do_start(16'd20, 16'h0400, 16'h0800);
    repeat (5) @(negedge clk);
    num_words = 16'd5; message_addr = 16'h0900; output_addr = 16'h0A00; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(edges);
    check("busy_start_done_edge", 256'(edges), 256'(174));
    check("busy_start_digest", digest, exp20);
    check_writes("busy_start", base, 16'h0800, exp20);

    // Back-to-back: start raised in the DONE cycle is ignored, accepted on the following edge.
    num_words = 16'd0; message_addr = 16'h1234; output_addr = 16'h0B00; start = 1'b1;
    @(posedge clk);
    #1 check("b2b_done_ignored", 256'(busy), 256'(0));
    @(posedge clk);
    #1 start = 1'b0;
    acc = cyc_cnt;
    check("b2b_accepted", 256'(busy), 256'(1));
    wait_done(edges);
    check("b2b_done_edge", 256'(edges), 256'(91));
    check("b2b_digest", digest, D_EMPTY);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
